approx_add_err_monitor: RTL and testbench

- Sequential error-characterization engine: the consumer end of the approximate-adder datapath.
- Accepts a stream of operand pairs together with the approximate adder's sum, and computes the exact sum internally.
- Accumulates error statistics (sample count, erroneous-sample count, sum of absolute error, maximum absolute error) over a programmed number of samples.
- Used in delay/MAE characterization benches, and on-chip beside RC_* approximate adders.

---
 rtl/approx_add_err_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_approx_add_err_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_err_monitor.sv
// approx_add_err_monitor
//   Error-characterisation engine for an approximate adder. Each accepted beat
//   carries two operands and the approximate adder's sum. The exact sum is
//   formed internally, and the engine accumulates sample count, erroneous-sample
//   count, saturating sum of absolute error and maximum absolute error over a
//   programmed number of samples.
//
//   Optional feature: define ERR_BIAS_EN to add sum_signed_err, a saturating
//   signed accumulation of (approx_sum - exact).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   start          one-cycle pulse; honoured in IDLE or DONE only
//   num_samples    samples per run, latched when start is accepted
//   in_valid       beat valid
//   in_ready       registered; high in RUN while accepted < num_samples
//   in1, in2       operands
//   approx_sum     approximate sum of in1 and in2 (WIDTH+1 bits)
//   busy           high in RUN and DRAIN
//   done           high in DONE; statistics are stable while it is high
//   sample_cnt     samples processed
//   err_cnt        samples whose approx_sum differs from in1+in2
//   sum_abs_err    saturating sum of |approx_sum - exact|
//   max_err        largest |approx_sum - exact| seen
//   sum_signed_err (ERR_BIAS_EN only) saturating sum of (approx_sum - exact)
module approx_add_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_err
`ifdef ERR_BIAS_EN
  ,
  output logic [ACC_W-1:0] sum_signed_err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One spare bit above the wider operand catches the carry-out for saturation.
  localparam int AW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] accepted;
  logic             accept;
  logic             start_acc;

  logic             s1_valid;
  logic [WIDTH:0]   s1_exact;
  logic [WIDTH:0]   s1_approx;
  logic [WIDTH:0]   s1_abs;
  logic             s2_valid;
  logic [WIDTH:0]   s2_abs;

  logic [AW-1:0]    abs_sum;
  logic [ACC_W-1:0] abs_next;

  assign accept    = in_valid && in_ready;
  assign start_acc = start && ((state == IDLE) || (state == DONE));

  // Control FSM; in_ready, busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      num_lat  <= '0;
      accepted <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_lat  <= num_samples;
            accepted <= '0;
            if (num_samples == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            accepted <= accepted + CNT_W'(1);
            if (accepted + CNT_W'(1) == num_lat) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Magnitude formed by ordered subtraction so no sign bit has to be dropped.
  always_comb begin
    s1_abs = (s1_approx >= s1_exact) ? (s1_approx - s1_exact)
                                     : (s1_exact - s1_approx);
  end

`ifdef ERR_BIAS_EN
  localparam int SW = ((ACC_W > WIDTH + 2) ? ACC_W : WIDTH + 2) + 1;

  logic signed [WIDTH+1:0] s1_diff;
  logic signed [WIDTH+1:0] s2_diff;
  logic signed [SW-1:0]    sgn_sum;
  logic signed [SW-1:0]    sgn_max;
  logic signed [SW-1:0]    sgn_min;
  logic [ACC_W-1:0]        sgn_next;

  always_comb begin
    s1_diff = $signed({1'b0, s1_approx}) - $signed({1'b0, s1_exact});
  end

  always_comb begin
    sgn_max = '0;
    sgn_max[ACC_W-2:0] = '1;
    sgn_min = '1;
    sgn_min[ACC_W-2:0] = '0;
    sgn_sum = SW'($signed(sum_signed_err)) + SW'(s2_diff);
    if (sgn_sum > sgn_max) begin
      sgn_next = sgn_max[ACC_W-1:0];
    end else if (sgn_sum < sgn_min) begin
      sgn_next = sgn_min[ACC_W-1:0];
    end else begin
      sgn_next = sgn_sum[ACC_W-1:0];
    end
  end
`endif

  // Two-stage datapath: S1 holds exact/approx, S2 holds the error magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= '0;
      s2_valid  <= 1'b0;
      s2_abs    <= '0;
`ifdef ERR_BIAS_EN
      s2_diff   <= '0;
`endif
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_exact  <= {1'b0, in1} + {1'b0, in2};
        s1_approx <= approx_sum;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_abs <= s1_abs;
`ifdef ERR_BIAS_EN
        s2_diff <= s1_diff;
`endif
      end
    end
  end

  always_comb begin
    abs_sum  = AW'(sum_abs_err) + AW'(s2_abs);
    abs_next = (|abs_sum[AW-1:ACC_W]) ? '1 : abs_sum[ACC_W-1:0];
  end

  // Statistics clear on reset and on an accepted start, then absorb S2 beats.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sample_cnt     <= '0;
      err_cnt        <= '0;
      sum_abs_err    <= '0;
      max_err        <= '0;
`ifdef ERR_BIAS_EN
      sum_signed_err <= '0;
`endif
    end else if (s2_valid) begin
      sample_cnt  <= sample_cnt + CNT_W'(1);
      err_cnt     <= err_cnt + CNT_W'(s2_abs != '0);
      sum_abs_err <= abs_next;
      if (s2_abs > max_err) begin
        max_err <= s2_abs;
      end
`ifdef ERR_BIAS_EN
      sum_signed_err <= sgn_next;
`endif
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Testbench for approx_add_err_monitor: table of beats with hand-derived error
// values, a scoreboard of expected running statistics checked two cycles after
// each accepted beat, and hand-written sequences for the multi-cycle cases.
// A second instance with ACC_W=17 exercises sum_abs_err saturation.
module tb_approx_add_err_monitor;
  localparam int W   = 16;
  localparam int CW  = 32;
  localparam int AW  = 48;
  localparam int AWS = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic [W:0]    approx_sum = '0;

  logic          in_ready, busy, done;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] sum_abs_err;
  logic [W:0]    max_err;

  logic           s_in_ready, s_busy, s_done;
  logic [CW-1:0]  s_sample_cnt, s_err_cnt;
  logic [AWS-1:0] s_sum_abs_err;
  logic [W:0]     s_max_err;
`ifdef ERR_BIAS_EN
  logic [AW-1:0]  sum_signed_err;
  logic [AWS-1:0] s_sum_signed_err;
`endif

  approx_add_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .approx_sum(approx_sum), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
    .max_err(max_err)
`ifdef ERR_BIAS_EN
    , .sum_signed_err(sum_signed_err)
`endif
  );

  approx_add_err_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in1(in1), .in2(in2),
    .approx_sum(approx_sum), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .sum_abs_err(s_sum_abs_err),
    .max_err(s_max_err)
`ifdef ERR_BIAS_EN
    , .sum_signed_err(s_sum_signed_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   ap;
    longint       eabs;
    longint       esgn;
  } vec_t;

  typedef struct {
    int unsigned due;
    logic [63:0] cnt;
    logic [63:0] err;
    logic [63:0] sum;
    logic [63:0] mx;
    logic [63:0] sgn;
  } exp_t;

  localparam logic [63:0] MASK48 = 64'h0000_FFFF_FFFF_FFFF;

  vec_t        vt[9];
  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  longint      m_cnt, m_err, m_sum, m_max, m_sgn;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sgn = 0;
  endtask

  // Called at the negedge before the accepting edge; stats land 3 negedges later.
  task automatic sb_push(input longint eabs, input longint esgn);
    exp_t e;
    m_cnt++;
    if (eabs != 0) m_err++;
    m_sum += eabs;
    if (m_sum > longint'(MASK48)) m_sum = longint'(MASK48);
    if (eabs > m_max) m_max = eabs;
    m_sgn += esgn;
    if (m_sgn > (64'sd1 <<< 47) - 1) m_sgn = (64'sd1 <<< 47) - 1;
    if (m_sgn < -(64'sd1 <<< 47)) m_sgn = -(64'sd1 <<< 47);
    e.due = cyc + 3;
    e.cnt = m_cnt;
    e.err = m_err;
    e.sum = m_sum;
    e.mx  = m_max;
    e.sgn = m_sgn & MASK48;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("sb_sample_cnt", 64'(sample_cnt), e.cnt);
      chk("sb_err_cnt", 64'(err_cnt), e.err);
      chk("sb_sum_abs_err", 64'(sum_abs_err), e.sum);
      chk("sb_max_err", 64'(max_err), e.mx);
`ifdef ERR_BIAS_EN
      chk("sb_sum_signed_err", 64'(sum_signed_err), e.sgn);
`endif
    end
    if (!rst) chk("busy_done_exclusive", 64'(busy & done), 64'd0);
  end

  task automatic start_run(input logic [CW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = n;
    model_clear();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input vec_t v);
    int t;
    bit fin;
    in1 = v.a; in2 = v.b; approx_sum = v.ap; in_valid = 1'b1;
    t = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (in_ready) begin
        sb_push(v.eabs, v.esgn);
        @(posedge clk); #1;
        fin = 1;
      end else begin
        @(posedge clk); #1;
        t++;
        if (t > 20) begin
          total++; bad++;
          $display("FAIL beat_accept: got no in_ready in 20 cycles want acceptance");
          fin = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(done), 64'd1);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int acc;
    vt[0] = '{a: 16'd3,      b: 16'd5, ap: 17'd8,       eabs: 0,     esgn: 0};
    vt[1] = '{a: 16'd1,      b: 16'd1, ap: 17'd2,       eabs: 0,     esgn: 0};
    vt[2] = '{a: 16'hFFFF,   b: 16'd1, ap: 17'h10000,   eabs: 0,     esgn: 0};
    vt[3] = '{a: 16'd3,      b: 16'd5, ap: 17'd6,       eabs: 2,     esgn: -2};
    vt[4] = '{a: 16'd2,      b: 16'd2, ap: 17'd7,       eabs: 3,     esgn: 3};
    vt[5] = '{a: 16'd0,      b: 16'd0, ap: 17'h0FFFF,   eabs: 65535, esgn: 65535};
    vt[6] = '{a: 16'd7,      b: 16'd0, ap: 17'd15,      eabs: 8,     esgn: 8};
    vt[7] = '{a: 16'd10,     b: 16'd20, ap: 17'd30,     eabs: 0,     esgn: 0};
    vt[8] = '{a: 16'd100,    b: 16'd1, ap: 17'd90,      eabs: 11,    esgn: -11};
    model_clear();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_sum_abs_err", 64'(sum_abs_err), 64'd0);
    chk("rst_max_err", 64'(max_err), 64'd0);

    // num_samples = 0: straight to DONE, never ready
    start_run(0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_in_ready", 64'(in_ready), 64'd0);
    chk("zero_sample_cnt", 64'(sample_cnt), 64'd0);

    // Exact results, including the carry-out case
    start_run(3);
    for (int i = 0; i < 3; i++) drive_beat(vt[i]);
    wait_done("exact_done");
    chk("exact_sample_cnt", 64'(sample_cnt), 64'd3);
    chk("exact_err_cnt", 64'(err_cnt), 64'd0);
    chk("exact_sum_abs_err", 64'(sum_abs_err), 64'd0);
    chk("exact_max_err", 64'(max_err), 64'd0);

    // Errors in both directions
    start_run(2);
    for (int i = 3; i < 5; i++) drive_beat(vt[i]);
    wait_done("err_done");
    chk("err_err_cnt", 64'(err_cnt), 64'd2);
    chk("err_sum_abs_err", 64'(sum_abs_err), 64'd5);
    chk("err_max_err", 64'(max_err), 64'd3);
`ifdef ERR_BIAS_EN
    chk("err_sum_signed_err", 64'(sum_signed_err), 64'd1);
`endif

    // in_valid held for 10 cycles with num_samples = 4
    start_run(4);
    in1 = vt[1].a; in2 = vt[1].b; approx_sum = vt[1].ap; in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc++;
        sb_push(vt[1].eabs, vt[1].esgn);
      end
      if (i == 4) chk("hold_ready_low_5th", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("hold_accepted", 64'(acc), 64'd4);
    wait_done("hold_done");
    chk("hold_sample_cnt", 64'(sample_cnt), 64'd4);

    // Reset in the middle of a run
    start_run(5);
    drive_beat(vt[7]);
    drive_beat(vt[8]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    model_clear();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("midrst_sum_abs_err", 64'(sum_abs_err), 64'd0);
    chk("midrst_max_err", 64'(max_err), 64'd0);
    start_run(1);
    drive_beat(vt[6]);
    wait_done("after_rst_done");
    chk("after_rst_max_err", 64'(max_err), 64'd8);
    chk("after_rst_err_cnt", 64'(err_cnt), 64'd1);
    chk("after_rst_sample_cnt", 64'(sample_cnt), 64'd1);

    // Saturation of the 17-bit accumulator
    start_run(3);
    for (int i = 0; i < 3; i++) drive_beat(vt[5]);
    wait_done("sat_done");
    chk("sat_s_done", 64'(s_done), 64'd1);
    chk("sat_s_busy", 64'(s_busy), 64'd0);
    chk("sat_s_in_ready", 64'(s_in_ready), 64'd0);
    chk("sat_s_sample_cnt", 64'(s_sample_cnt), 64'd3);
    chk("sat_s_err_cnt", 64'(s_err_cnt), 64'd3);
    chk("sat_s_max_err", 64'(s_max_err), 64'hFFFF);
    chk("sat_s_sum_abs_err", 64'(s_sum_abs_err), 64'h1FFFF);
    chk("sat_sum_abs_err", 64'(sum_abs_err), 64'h2FFFD);
`ifdef ERR_BIAS_EN
    chk("sat_s_sum_signed_err", 64'(s_sum_signed_err), 64'h0FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
